// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive path with oversampling and majority-vote sampling.
// The serial line is synchronized, the start bit is qualified, data is
// deserialized LSB first, and optional parity and the stop bit are checked.
// A good frame is presented as a parallel word with a one-cycle strobe.
//
// Ports:
//   clk        oversampling clock, PRESCALE cycles per bit
//   rstn       asynchronous active-low reset
//   rx_in      serial line, idle high, asynchronous to clk
//   par_en     1 = frame carries a parity bit (latched at start of frame)
//   par_typ    0 = even, 1 = odd parity (latched at start of frame)
//   p_data     last good received word
//   data_valid one-cycle pulse, p_data updated
//   par_err    one-cycle pulse, parity mismatch
//   stop_err   one-cycle pulse, stop bit sampled 0
//   busy       high while a frame is in progress
module uart_rx_fsm #(
   parameter int DATA_WIDTH = 8,
   parameter int PRESCALE   = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  rx_in,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [DATA_WIDTH-1:0] p_data,
   output logic                  data_valid,
   output logic                  par_err,
   output logic                  stop_err,
   output logic                  busy
);

   localparam int EW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
   localparam logic [EW-1:0] E_S0   = EW'(PRESCALE / 2 - 1);
   localparam logic [EW-1:0] E_S1   = EW'(PRESCALE / 2);
   localparam logic [EW-1:0] E_S2   = EW'(PRESCALE / 2 + 1);
   localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [EW-1:0]         edge_cnt_q, edge_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic [2:0]            smp_q, smp_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  pen_q, pen_d;
   logic                  ptyp_q, ptyp_d;
   logic                  perr_q, perr_d;
   logic                  data_valid_q, data_valid_d;
   logic                  par_err_q, par_err_d;
   logic                  stop_err_q, stop_err_d;
   logic                  busy_q, busy_d;
   logic                  sync1_q, sync2_q;

   logic rx_s;
   logic bit_end;
   logic m2;
   logic maj;

   assign rx_s    = sync2_q;
   assign bit_end = (edge_cnt_q == E_LAST);
   // With PRESCALE=4 the third sample point coincides with the decision
   // cycle, so take the live value there instead of the stored one.
   assign m2      = (edge_cnt_q == E_S2) ? rx_s : smp_q[2];
   assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & m2) | (smp_q[1] & m2);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_in;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q      <= IDLE;
         edge_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         smp_q        <= 3'b111;
         shift_q      <= '0;
         p_data_q     <= '0;
         pen_q        <= 1'b0;
         ptyp_q       <= 1'b0;
         perr_q       <= 1'b0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stop_err_q   <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         edge_cnt_q   <= edge_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         smp_q        <= smp_d;
         shift_q      <= shift_d;
         p_data_q     <= p_data_d;
         pen_q        <= pen_d;
         ptyp_q       <= ptyp_d;
         perr_q       <= perr_d;
         data_valid_q <= data_valid_d;
         par_err_q    <= par_err_d;
         stop_err_q   <= stop_err_d;
         busy_q       <= busy_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      edge_cnt_d   = edge_cnt_q;
      bit_cnt_d    = bit_cnt_q;
      smp_d        = smp_q;
      shift_d      = shift_q;
      p_data_d     = p_data_q;
      pen_d        = pen_q;
      ptyp_d       = ptyp_q;
      perr_d       = perr_q;
      busy_d       = busy_q;
      data_valid_d = 1'b0;
      par_err_d    = 1'b0;
      stop_err_d   = 1'b0;

      if (state_q != IDLE) begin
         edge_cnt_d = bit_end ? '0 : edge_cnt_q + EW'(1);
         if (edge_cnt_q == E_S0) smp_d[0] = rx_s;
         if (edge_cnt_q == E_S1) smp_d[1] = rx_s;
         if (edge_cnt_q == E_S2) smp_d[2] = rx_s;
      end

      case (state_q)
         IDLE: begin
            busy_d     = 1'b0;
            edge_cnt_d = '0;
            // The first low cycle is edge 0 of the start bit.
            if (!rx_s) begin
               state_d    = START;
               edge_cnt_d = EW'(1);
               busy_d     = 1'b1;
               pen_d      = par_en;
               ptyp_d     = par_typ;
               perr_d     = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               if (maj) begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end else begin
                  state_d   = DATA;
                  bit_cnt_d = '0;
               end
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               shift_d[DATA_WIDTH-1] = maj;
               if (bit_cnt_q == B_LAST) begin
                  state_d = pen_q ? PARITY : STOP;
               end else begin
                  bit_cnt_d = bit_cnt_q + BW'(1);
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               perr_d  = (maj != ((^shift_q) ^ ptyp_q));
               state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               if (!perr_q && maj) begin
                  data_valid_d = 1'b1;
                  p_data_d     = shift_q;
               end else begin
                  par_err_d  = perr_q;
                  stop_err_d = ~maj;
               end
            end
         end
         default: begin
            state_d    = IDLE;
            busy_d     = 1'b0;
            edge_cnt_d = '0;
         end
      endcase
   end

   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stop_err   = stop_err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Testbench for uart_rx_fsm: directed frames plus randomized frames, checked
// against a frame-level reference model.
module tb_uart_rx_fsm;

   localparam int DW = 8;
   localparam int P  = 8;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          rx_in = 1'b1;
   logic          par_en = 1'b0;
   logic          par_typ = 1'b0;
   logic [DW-1:0] p_data;
   logic          data_valid, par_err, stop_err, busy;

   uart_rx_fsm #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
      .clk(clk), .rstn(rstn), .rx_in(rx_in), .par_en(par_en), .par_typ(par_typ),
      .p_data(p_data), .data_valid(data_valid), .par_err(par_err),
      .stop_err(stop_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // pulse monitor
   int            dv_n = 0, pe_n = 0, se_n = 0, wide_n = 0, busy_n = 0;
   int            dv_cyc = 0, dv_prev_cyc = 0;
   logic [DW-1:0] dv_last = '0, dv_prev_val = '0;
   logic          dv_d1 = 1'b0, pe_d1 = 1'b0, se_d1 = 1'b0;

   always @(negedge clk) begin
      if (data_valid) begin
         dv_n++;
         dv_prev_cyc = dv_cyc;
         dv_prev_val = dv_last;
         dv_cyc      = cyc;
         dv_last     = p_data;
      end
      if (par_err)  pe_n++;
      if (stop_err) se_n++;
      if (busy)     busy_n++;
      if ((data_valid && dv_d1) || (par_err && pe_d1) || (stop_err && se_d1)) wide_n++;
      dv_d1 = data_valid;
      pe_d1 = par_err;
      se_d1 = stop_err;
   end

   int            total = 0, bad = 0;
   int            fall_cyc = 0;
   logic [DW-1:0] exp_pd = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   // Expected {valid, par_err, stop_err} of a frame, from bit counts.
   function automatic logic [2:0] ref_frame(input logic [DW-1:0] d, input logic pe,
                                            input logic pt, input logic pbit,
                                            input logic sbit);
      logic perr, serr;
      perr = pe && ((($countones(d) + int'(pbit)) % 2) != int'(pt));
      serr = !sbit;
      return {!perr && !serr, perr, serr};
   endfunction

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic b, input int flip_at);
      for (int j = 0; j < P; j++) begin
         rx_in = (j == flip_at) ? ~b : b;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input logic pbit, input logic sbit, input logic noise,
                             input logic scramble);
      par_en   = pe;
      par_typ  = pt;
      fall_cyc = cyc;
      drive_bit(1'b0, -1);
      if (scramble) begin
         par_en  = 1'($urandom);
         par_typ = 1'($urandom);
      end
      for (int i = 0; i < DW; i++) drive_bit(d[i], noise ? P / 2 : -1);
      if (pe) drive_bit(pbit, -1);
      drive_bit(sbit, -1);
      rx_in = 1'b1;
   endtask

   task automatic frame_check(input string tag, input logic [DW-1:0] d, input logic pe,
                              input logic pt, input logic pbit, input logic sbit,
                              input logic noise, input logic scramble);
      int dv0, pe0, se0, lat, need;
      logic [2:0] e;
      dv0 = dv_n; pe0 = pe_n; se0 = se_n;
      e = ref_frame(d, pe, pt, pbit, sbit);
      send_frame(d, pe, pt, pbit, sbit, noise, scramble);
      idle(6);
      chk({tag, ".dv"}, 32'(dv_n - dv0), 32'(e[2]));
      chk({tag, ".pe"}, 32'(pe_n - pe0), 32'(e[1]));
      chk({tag, ".se"}, 32'(se_n - se0), 32'(e[0]));
      if (e[2]) begin
         exp_pd = d;
         lat  = dv_cyc - fall_cyc;
         need = 2 + P * (DW + 2 + int'(pe));
         chk({tag, ".lat"}, 32'(lat), (lat >= need - 1 && lat <= need + 1) ? 32'(lat) : 32'(need));
      end
      chk({tag, ".pdata"}, 32'(p_data), 32'(exp_pd));
   endtask

   initial begin
      int b0, dv0, pe0, se0;
      logic [DW-1:0] d;
      logic pe, pt, pbit, sbit, nz;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst.pdata", 32'(p_data), 32'h0);
      chk("rst.flags", 32'({data_valid, par_err, stop_err, busy}), 32'h0);
      rstn = 1'b1;
      idle(4);

      // basic frame, busy duration
      b0 = busy_n;
      frame_check("basic", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("basic.busy", 32'(busy_n - b0 >= 79 && busy_n - b0 <= 80), 32'h1);

      // even parity good then bad
      frame_check("even_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      frame_check("even_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // odd parity with framing error
      frame_check("odd_ferr", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

      // glitch rejection
      dv0 = dv_n; pe0 = pe_n; se0 = se_n;
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      idle(4);
      chk("glitch.busy_hi", 32'(busy), 32'h1);
      idle(12);
      chk("glitch.busy_lo", 32'(busy), 32'h0);
      chk("glitch.pulses", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'h0);
      frame_check("after_glitch", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

      // single-cycle noise at mid-bit
      frame_check("noise", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      frame_check("noise_par", 8'h96, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

      // reset in the middle of DATA
      dv0 = dv_n; pe0 = pe_n; se0 = se_n;
      par_en = 1'b0;
      drive_bit(1'b0, -1);
      drive_bit(1'b1, -1);
      drive_bit(1'b0, -1);
      drive_bit(1'b1, -1);
      rstn  = 1'b0;
      rx_in = 1'b1;
      @(negedge clk);
      chk("midrst.pdata", 32'(p_data), 32'h0);
      chk("midrst.flags", 32'({data_valid, par_err, stop_err, busy}), 32'h0);
      exp_pd = '0;
      idle(3);
      rstn = 1'b1;
      idle(100);
      chk("midrst.pulses", 32'((dv_n - dv0) + (pe_n - pe0) + (se_n - se0)), 32'h0);
      chk("midrst.busy", 32'(busy), 32'h0);

      // back-to-back frames
      dv0 = dv_n;
      send_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      send_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(6);
      chk("b2b.count", 32'(dv_n - dv0), 32'h2);
      chk("b2b.gap", 32'(dv_cyc - dv_prev_cyc), 32'd80);
      chk("b2b.first", 32'(dv_prev_val), 32'h12);
      chk("b2b.second", 32'(dv_last), 32'h34);
      exp_pd = 8'h34;

      // break: line stays low after a framing error
      se0 = se_n; dv0 = dv_n;
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      rx_in = 1'b0;
      repeat (10 * P) @(negedge clk);
      idle(6);
      chk("break.se", 32'(se_n - se0), 32'h2);
      chk("break.dv", 32'(dv_n - dv0), 32'h0);
      chk("break.busy", 32'(busy), 32'h0);

      // randomized frames, parity inputs scrambled mid-frame
      for (int k = 0; k < 40; k++) begin
         d    = DW'($urandom);
         pe   = 1'($urandom);
         pt   = 1'($urandom);
         pbit = 1'($urandom);
         sbit = ($urandom_range(0, 3) != 0);
         nz   = 1'($urandom);
         frame_check($sformatf("rnd%0d", k), d, pe, pt, pbit, sbit, nz, 1'b1);
         idle($urandom_range(0, 5));
      end

      chk("pulse_width", 32'(wide_n), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
